contador_regressivo: RTL and testbench

CONTADOR_REGRESSIVO -- requirements
Module: contador_regressivo

---
 rtl/contador_regressivo_if.sv | 38 +++
 rtl/contador_regressivo.sv | 78 +++++++
 tb/tb_contador_regressivo.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/contador_regressivo_if.sv
// Control and status bundle of the loadable down-counter.
interface contador_regressivo_if #(
    parameter int N = 12
);
    logic         zera_s;
    logic         inicia;
    logic         conta;
    logic [N-1:0] valor;
    logic [N-1:0] Q;
    logic         fim;
    logic         meio;
    logic         ocupado;
    logic         expirado;

    modport master (
        output zera_s,
        output inicia,
        output conta,
        output valor,
        input  Q,
        input  fim,
        input  meio,
        input  ocupado,
        input  expirado
    );

    modport slave (
        input  zera_s,
        input  inicia,
        input  conta,
        input  valor,
        output Q,
        output fim,
        output meio,
        output ocupado,
        output expirado
    );
endinterface

// File: rtl/contador_regressivo.sv
// Saturating loadable down-counter with pause, half-way flag
// and a one-cycle expiry pulse.
module contador_regressivo #(
    parameter int M = 3000,
    parameter int N = 12
) (
    input  logic                  clock,
    input  logic                  zera_as,
    contador_regressivo_if.slave  bus
);
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        EXPIRADO = 2'd2
    } estado_t;

    localparam logic [N-1:0] MAXV = N'(M - 1);
    localparam logic [N-1:0] UM   = N'(1);

    estado_t      st_q, st_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] carga_q, carga_d;
    logic         fim_q, fim_d;
    logic [N-1:0] carga_l;

    assign carga_l = (bus.valor > MAXV) ? MAXV : bus.valor;

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        carga_d = carga_q;
        fim_d   = 1'b0;
        if (bus.zera_s) begin
            st_d    = OCIOSO;
            cnt_d   = '0;
            carga_d = '0;
        end else if (bus.inicia) begin
            cnt_d   = carga_l;
            carga_d = carga_l;
            if (carga_l != '0) begin
                st_d = CONTANDO;
            end else begin
                st_d  = EXPIRADO;
                // Re-entering from EXPIRADO is not a new expiry.
                fim_d = (st_q != EXPIRADO);
            end
        end else if (st_q == CONTANDO && bus.conta) begin
            if (cnt_q > UM) begin
                cnt_d = cnt_q - UM;
            end else begin
                cnt_d = '0;
                st_d  = EXPIRADO;
                fim_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            st_q    <= OCIOSO;
            cnt_q   <= '0;
            carga_q <= '0;
            fim_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            carga_q <= carga_d;
            fim_q   <= fim_d;
        end
    end

    assign bus.Q        = cnt_q;
    assign bus.fim      = fim_q;
    assign bus.ocupado  = (st_q == CONTANDO);
    assign bus.expirado = (st_q == EXPIRADO);
    assign bus.meio     = (st_q == CONTANDO) &&
                          ({cnt_q, 1'b0} <= {1'b0, carga_q});
endmodule

// File: tb/tb_contador_regressivo.sv
// Scoreboard bench for contador_regressivo: directed scenarios
// followed by random traffic against a behavioural model.
module tb_contador_regressivo;
    localparam int M = 10;
    localparam int N = 4;

    logic clock = 1'b0;
    logic zera_as;

    always #5 clock = ~clock;

    contador_regressivo_if #(.N(N)) bus ();

    contador_regressivo #(.M(M), .N(N)) dut (
        .clock   (clock),
        .zera_as (zera_as),
        .bus     (bus)
    );

    typedef struct {
        logic [N+3:0] v;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference: mode 0 idle, 1 counting, 2 expired
    int m_mode  = 0;
    int m_q     = 0;
    int m_carga = 0;
    bit m_fim   = 1'b0;

    function automatic logic [N+3:0] outs();
        return {bus.Q, bus.fim, bus.meio, bus.ocupado, bus.expirado};
    endfunction

    function automatic logic [N+3:0] model_outs();
        logic half;
        half = (m_mode == 1) && (2 * m_q <= m_carga);
        return {N'(m_q), m_fim, half, m_mode == 1, m_mode == 2};
    endfunction

    task automatic check(string tag, logic [N+3:0] got, logic [N+3:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got Q/fim/meio/ocup/exp=%b required %b",
                      tag, got, exp);
    endtask

    task automatic model_step(bit zs, bit ini, bit cn, int val);
        int load;
        if (zs) begin
            m_mode = 0; m_q = 0; m_carga = 0; m_fim = 0;
        end else if (ini) begin
            load    = (val > M - 1) ? M - 1 : val;
            m_q     = load;
            m_carga = load;
            if (load > 0) begin
                m_fim  = 0;
                m_mode = 1;
            end else begin
                m_fim  = (m_mode != 2);
                m_mode = 2;
            end
        end else if (m_mode == 1 && cn) begin
            m_q   = m_q - 1;
            m_fim = (m_q == 0);
            if (m_q == 0) m_mode = 2;
        end else begin
            m_fim = 0;
        end
    endtask

    task automatic cyc(string tag, bit zs, bit ini, bit cn, int val);
        exp_t e;
        @(negedge clock);
        bus.zera_s = zs;
        bus.inicia = ini;
        bus.conta  = cn;
        bus.valor  = N'(val);
        model_step(zs, ini, cn, val);
        e.v   = model_outs();
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic async_reset(string tag);
        exp_t e;
        @(negedge clock);
        bus.zera_s = 1'b0;
        bus.inicia = 1'b0;
        bus.conta  = 1'b1;
        #2 zera_as = 1'b1;
        #1 check(tag, outs(), '0);
        model_step(1'b1, 1'b0, 1'b0, 0);
        e.v   = model_outs();
        e.tag = {tag, "_hold"};
        sb.push_back(e);
        @(negedge clock);
        zera_as = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.tag, outs(), e.v);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        zera_as    = 1'b1;
        bus.zera_s = 1'b0;
        bus.inicia = 1'b0;
        bus.conta  = 1'b0;
        bus.valor  = '0;
        #1 check("reset", outs(), '0);
        repeat (2) @(negedge clock);
        zera_as = 1'b0;

        cyc("basic_load", 0, 1, 1, 3);
        repeat (3) cyc("basic_cnt", 0, 0, 1, 0);
        repeat (2) cyc("basic_exp", 0, 0, 1, 0);

        cyc("sat_load", 0, 1, 0, 15);
        repeat (3) cyc("sat_hold", 0, 0, 0, 0);
        repeat (6) cyc("sat_meio", 0, 0, 1, 0);

        cyc("pause_load", 0, 1, 1, 6);
        repeat (2) cyc("pause_cnt", 0, 0, 1, 0);
        repeat (5) cyc("pause_hold", 0, 0, 0, 0);
        cyc("reload", 0, 1, 1, 2);
        repeat (3) cyc("reload_cnt", 0, 0, 1, 0);

        cyc("zero_idle", 1, 0, 0, 0);
        repeat (3) cyc("zero_load", 0, 1, 0, 0);
        repeat (2) cyc("zero_stay", 0, 0, 1, 0);

        cyc("rst_load", 0, 1, 1, 8);
        repeat (3) cyc("rst_cnt", 0, 0, 1, 0);
        async_reset("async_mid");
        repeat (2) cyc("after_async", 0, 0, 1, 0);
        cyc("rst_load2", 0, 1, 1, 8);
        repeat (3) cyc("rst_cnt2", 0, 0, 1, 0);
        cyc("sync_rst", 1, 1, 1, 7);
        repeat (2) cyc("after_sync", 0, 0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            if (($urandom % 60) == 0) async_reset("rand_async");
            else cyc("random", ($urandom % 25) == 0, ($urandom % 7) == 0,
                     ($urandom % 4) != 0, int'($urandom % 16));
        end

        repeat (3) @(negedge clock);
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending required 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
